// File: rtl/gf_mult_seq_ctrl.sv
// Sequencer for a bit-serial GF(2) multiplier: serialises an operand pair in, pulses enable,
// waits for finish with a timeout, then deserialises the double-width product.
module gf_mult_seq_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int TIMEOUT      = 64,
    parameter int UNLOAD_DELAY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    input  logic                      op_width,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH-1:0]   res_data,
    output logic                      res_err,
    output logic                      busy,
    output logic                      mul_enable,
    output logic                      mul_width,
    output logic                      mul_in_a,
    output logic                      mul_in_b,
    input  logic                      mul_out,
    input  logic                      mul_finish
);

    localparam int PW      = 2 * DATA_WIDTH;
    localparam int CNT_MAX = (TIMEOUT > PW) ? ((TIMEOUT > UNLOAD_DELAY) ? TIMEOUT : UNLOAD_DELAY)
                                            : ((PW > UNLOAD_DELAY) ? PW : UNLOAD_DELAY);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((UNLOAD_DELAY > 0) ? UNLOAD_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(PW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] a_sr;
    logic [DATA_WIDTH-1:0] b_sr;
    logic                  width_q;
    logic [PW-1:0]         prod_sr;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        next_state = state;
        op_ready   = 1'b0;
        busy       = 1'b1;
        res_valid  = 1'b0;
        mul_enable = 1'b0;
        mul_in_a   = 1'b0;
        mul_in_b   = 1'b0;
        mul_width  = width_q;
        case (state)
            S_IDLE: begin
                op_ready  = 1'b1;
                busy      = 1'b0;
                mul_width = 1'b0;
                if (op_valid) next_state = S_LOAD;
            end
            S_LOAD: begin
                mul_in_a = a_sr[DATA_WIDTH-1];
                mul_in_b = b_sr[DATA_WIDTH-1];
                if (cnt == LOAD_LAST) next_state = S_START;
            end
            S_START: begin
                mul_enable = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (mul_finish)             next_state = (UNLOAD_DELAY == 0) ? S_UNLOAD : S_GAP;
                else if (cnt == WAIT_LAST)  next_state = S_DONE;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) next_state = S_UNLOAD;
            end
            S_UNLOAD: begin
                if (cnt == UNLOAD_LAST) next_state = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so res_data reads 0 immediately after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            width_q  <= 1'b0;
            prod_sr  <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            // The WAIT counter starts at 1 so that reaching TIMEOUT means TIMEOUT cycles waited.
            if (next_state != state) cnt <= (next_state == S_WAIT) ? CNT_W'(1) : '0;
            else                     cnt <= cnt + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        a_sr    <= op_a;
                        b_sr    <= op_b;
                        width_q <= op_width;
                    end
                end
                S_LOAD: begin
                    a_sr <= a_sr << 1;
                    b_sr <= b_sr << 1;
                end
                S_WAIT: begin
                    if (next_state == S_DONE) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end
                end
                S_UNLOAD: begin
                    prod_sr <= {prod_sr[PW-2:0], mul_out};
                    if (next_state == S_DONE) begin
                        res_data <= {prod_sr[PW-2:0], mul_out};
                        res_err  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (next_state == S_IDLE) res_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
